// File: rtl/dma_desc_dispatcher.sv
// rtl/dma_desc_dispatcher.sv - descriptor FIFO feeding paired read/write engine trackers
// Optional perf counters enabled by DMA_DISPATCH_PERF_EN.
module dma_desc_dispatcher #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              desc_valid,
  input  logic [ADDR_W-1:0] desc_src_addr,
  input  logic [ADDR_W-1:0] desc_dest_addr,
  input  logic [LEN_W-1:0]  desc_length,
  input  logic [1:0]        desc_mode,
  output logic              desc_ready,
  input  logic              engine_reset,
  output logic              rd_cmd_valid,
  input  logic              rd_cmd_ready,
  output logic [ADDR_W-1:0] rd_cmd_addr,
  output logic [LEN_W-1:0]  rd_cmd_length,
  output logic [1:0]        rd_cmd_mode,
  output logic              wr_cmd_valid,
  input  logic              wr_cmd_ready,
  output logic [ADDR_W-1:0] wr_cmd_addr,
  output logic [LEN_W-1:0]  wr_cmd_length,
  output logic [1:0]        wr_cmd_mode,
  input  logic              rd_done,
  input  logic              wr_done,
  output logic              desc_done,
  output logic              err_sticky,
  output logic [32:0]       status_fifo_count,
  output logic [32:0]       status_fifo_depth,
  output logic [15:0]       status_rd_state,
  output logic [15:0]       status_wr_state,
  output logic [31:0]       perf_desc_count,
  output logic [31:0]       perf_busy_cycles
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_BUSY = 2'd2
  } trk_state_t;

  logic [ADDR_W-1:0] mem_src  [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_dest [FIFO_DEPTH];
  logic [LEN_W-1:0]  mem_len  [FIFO_DEPTH];
  logic [1:0]        mem_mode [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  trk_state_t        rd_state, rd_next, wr_state, wr_next;
  logic              active;
  logic              push, pop, pop_zero, push_err, rd_err, wr_err, done_next;
  logic [ADDR_W-1:0] cur_src, cur_dest;
  logic [LEN_W-1:0]  cur_len;
  logic [1:0]        cur_mode;

  assign desc_ready = (count < (PTR_W+1)'(FIFO_DEPTH));
  assign push       = desc_valid & desc_ready & (desc_mode != 2'd3) & ~engine_reset;
  assign push_err   = desc_valid & (~desc_ready | (desc_mode == 2'd3));
  assign pop        = (count != '0) & (rd_state == ST_IDLE) & (wr_state == ST_IDLE)
                      & ~desc_done & ~engine_reset;
  assign pop_zero   = (mem_len[rd_ptr] == '0);
  assign rd_err     = rd_done & (rd_state != ST_BUSY);
  assign wr_err     = wr_done & (wr_state != ST_BUSY);

  always_comb begin
    rd_next = rd_state;
    wr_next = wr_state;
    case (rd_state)
      ST_IDLE: if (pop && !pop_zero) rd_next = ST_CMD;
      ST_CMD:  if (rd_cmd_ready) rd_next = ST_BUSY;
      ST_BUSY: if (rd_done) rd_next = ST_IDLE;
      default: rd_next = ST_IDLE;
    endcase
    case (wr_state)
      ST_IDLE: if (pop && !pop_zero) wr_next = ST_CMD;
      ST_CMD:  if (wr_cmd_ready) wr_next = ST_BUSY;
      ST_BUSY: if (wr_done) wr_next = ST_IDLE;
      default: wr_next = ST_IDLE;
    endcase
    // Zero-length descriptors complete straight from the pop; others when both sides drain.
    done_next = (pop && pop_zero) ||
                (active && rd_next == ST_IDLE && wr_next == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_src[wr_ptr]  <= desc_src_addr;
      mem_dest[wr_ptr] <= desc_dest_addr;
      mem_len[wr_ptr]  <= desc_length;
      mem_mode[wr_ptr] <= desc_mode;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_state   <= ST_IDLE;
      wr_state   <= ST_IDLE;
      active     <= 1'b0;
      desc_done  <= 1'b0;
      err_sticky <= 1'b0;
      cur_src    <= '0;
      cur_dest   <= '0;
      cur_len    <= '0;
      cur_mode   <= '0;
    end else if (engine_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_state   <= ST_IDLE;
      wr_state   <= ST_IDLE;
      active     <= 1'b0;
      desc_done  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      rd_state   <= rd_next;
      wr_state   <= wr_next;
      desc_done  <= done_next;
      err_sticky <= err_sticky | push_err | rd_err | wr_err;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (pop) begin
        active   <= !pop_zero;
        cur_src  <= mem_src[rd_ptr];
        cur_dest <= mem_dest[rd_ptr];
        cur_len  <= mem_len[rd_ptr];
        cur_mode <= mem_mode[rd_ptr];
      end else if (active && rd_next == ST_IDLE && wr_next == ST_IDLE) begin
        active <= 1'b0;
      end
    end
  end

  assign rd_cmd_valid      = (rd_state == ST_CMD);
  assign wr_cmd_valid      = (wr_state == ST_CMD);
  assign rd_cmd_addr       = cur_src;
  assign wr_cmd_addr       = cur_dest;
  assign rd_cmd_length     = cur_len;
  assign wr_cmd_length     = cur_len;
  assign rd_cmd_mode       = cur_mode;
  assign wr_cmd_mode       = cur_mode;
  assign status_fifo_count = 33'(count);
  assign status_fifo_depth = 33'(FIFO_DEPTH);
  assign status_rd_state   = {14'd0, rd_state};
  assign status_wr_state   = {14'd0, wr_state};

`ifdef DMA_DISPATCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_desc_count  <= '0;
      perf_busy_cycles <= '0;
    end else if (engine_reset) begin
      perf_desc_count  <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (desc_done && perf_desc_count != '1)
        perf_desc_count <= perf_desc_count + 1'b1;
      if ((rd_state != ST_IDLE || wr_state != ST_IDLE) && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 1'b1;
    end
  end
`else
  assign perf_desc_count  = '0;
  assign perf_busy_cycles = '0;
`endif

endmodule

// File: doc/dma_desc_dispatcher.md
DMA_DESC_DISPATCHER -- requirements
Module: dma_desc_dispatcher

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, descriptor FIFO entries (power of 2, 2..256).
REQ-002 SHALL have parameter ADDR_W, default 32, source/destination address width.
REQ-003 SHALL have parameter LEN_W, default 32, transfer length width in bytes.
REQ-004 SHALL have port clk  in  1  sole clock; all logic is rising-edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports desc_valid in 1, desc_src_addr in ADDR_W, desc_dest_addr in ADDR_W, desc_length in LEN_W, desc_mode in 2: descriptor push, host side.
REQ-007 SHALL have port desc_ready  out  1  FIFO not full.
REQ-008 SHALL have port engine_reset  in  1  synchronous soft flush.
REQ-009 SHALL have ports rd_cmd_valid out 1, rd_cmd_ready in 1, rd_cmd_addr out ADDR_W, rd_cmd_length out LEN_W, rd_cmd_mode out 2: read-engine command.
REQ-010 SHALL have ports wr_cmd_valid out 1, wr_cmd_ready in 1, wr_cmd_addr out ADDR_W, wr_cmd_length out LEN_W, wr_cmd_mode out 2: write-engine command.
REQ-011 SHALL have ports rd_done in 1 and wr_done in 1: single-cycle engine completion pulses.
REQ-012 SHALL have ports desc_done out 1 (completion pulse), err_sticky out 1, status_fifo_count out 33, status_fifo_depth out 33, status_rd_state out 16, status_wr_state out 16.
REQ-013 SHALL have ports perf_desc_count out 32 and perf_busy_cycles out 32.

Function
REQ-014 Push SHALL occur when desc_valid and desc_ready; desc_ready = count < FIFO_DEPTH, registered state only; a pop in the same cycle does not raise desc_ready.
REQ-015 Push with desc_valid while full SHALL be dropped and set err_sticky.
REQ-016 Push with desc_mode==3 SHALL be dropped (not stored) and set err_sticky; modes 0=HOST_TO_DDR, 1=DDR_TO_HOST, 2=DDR_TO_DDR.
REQ-017 Simultaneous push and pop SHALL leave status_fifo_count unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-018 status_fifo_depth SHALL equal FIFO_DEPTH constant; status_fifo_count SHALL equal occupancy 0..FIFO_DEPTH, zero-extended.
REQ-019 Read and write trackers SHALL each be an FSM: IDLE(0) -> CMD(1) -> BUSY(2) -> IDLE; status_rd_state/status_wr_state = state code zero-extended to 16 bits.
REQ-020 Pop SHALL occur in a cycle where FIFO non-empty and both trackers IDLE and desc_done not asserted; both trackers enter CMD on the next edge.
REQ-021 Popped descriptor with length 0 SHALL not enter CMD; desc_done SHALL pulse the cycle after pop.
REQ-022 In CMD, *_cmd_valid SHALL be 1 with addr/length/mode held stable until *_cmd_ready; handshake moves tracker to BUSY.
REQ-023 rd_cmd_addr SHALL be src_addr; wr_cmd_addr SHALL be dest_addr; both lengths and modes equal the descriptor's.
REQ-024 *_done SHALL be honoured only in BUSY (-> IDLE next edge); done in IDLE or CMD SHALL be ignored and set err_sticky.
REQ-025 desc_done SHALL pulse one cycle on the edge both trackers reach IDLE for the active descriptor; trackers finishing in different cycles give one pulse only.
REQ-026 engine_reset SHALL, next edge, empty FIFO, force both trackers IDLE, clear err_sticky and perf counters, deassert all command valids; no desc_done for the flushed descriptor.
REQ-027 err_sticky SHALL hold until reset or engine_reset.

Reset
REQ-028 On reset, all outputs SHALL be 0 except desc_ready=1 and status_fifo_depth=FIFO_DEPTH; FIFO empty; trackers IDLE.
REQ-029 Reset assertion mid-transfer SHALL abort immediately; subsequent done pulses before a new command are ignored per REQ-024.

Configuration
REQ-030 With DMA_DISPATCH_PERF_EN defined, perf_desc_count SHALL increment per desc_done and perf_busy_cycles per cycle with any tracker not IDLE, both saturating at 2^32-1.
REQ-031 Without DMA_DISPATCH_PERF_EN, perf_desc_count and perf_busy_cycles SHALL be constant 0 and no counter logic exists.

Verification
REQ-032 Push 1 descriptor (src 0x1000, dest 0x2000, len 64, mode 0), ready held 1, done 3 cycles after each handshake -> rd_cmd_addr 0x1000, wr_cmd_addr 0x2000, single desc_done, count back to 0.
REQ-033 Push 17 descriptors back-to-back, engines stalled -> count 16, 17th dropped, desc_ready 0, err_sticky 1.
REQ-034 Descriptor len 0 then len 32 -> no command for first, desc_done pulse, second issued next.
REQ-035 rd_done 2 cycles, wr_done 10 cycles after commands -> status_rd_state 0 while wr 2, exactly one desc_done.
REQ-036 engine_reset while trackers BUSY with 3 queued -> count 0, states 0, no desc_done; late rd_done sets err_sticky.
REQ-037 With DMA_DISPATCH_PERF_EN, 4 descriptors each 5 busy cycles -> perf_desc_count 4, perf_busy_cycles 20; without it, both 0.
